rib_dma: RTL
============

RIB_DMA -- requirements
Module: rib_dma

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, giving the per-handshake ack wait limit in clock cycles (used only when RIB_DMA_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-004 SHALL have port start_i, input, 1, single-cycle request to begin a copy.
REQ-005 SHALL have port src_i, input, 32, source byte address (word aligned).
REQ-006 SHALL have port dst_i, input, 32, destination byte address (word aligned).
REQ-007 SHALL have port len_i, input, 16, number of 32-bit words to copy.
REQ-008 SHALL have port busy_o, output, 1, copy in progress.
REQ-009 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port err_o, output, 1, sticky timeout flag, cleared by the next accepted start_i.
REQ-011 SHALL have port req_o, output, 1, RIB bus request (initiator side).
REQ-012 SHALL have port we_o, output, 1, RIB write enable.
REQ-013 SHALL have port addr_o, output, 32, RIB byte address.
REQ-014 SHALL have port data_o, output, 32, RIB write data.
REQ-015 SHALL have port data_i, input, 32, RIB read data; valid in the cycle ack_i is high.
REQ-016 SHALL have port ack_i, input, 1, RIB responder acknowledge; may be high in the same cycle req_o rises.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, DONE; all outputs SHALL be registered.
REQ-018 In IDLE, start_i=1 SHALL latch src_i, dst_i, len_i and clear err_o; with len_i=0 go to DONE, else go to READ.
REQ-019 start_i SHALL be ignored in every state except IDLE.
REQ-020 In READ: req_o=1, we_o=0, addr_o=current source address; on a cycle with ack_i=1, data_i SHALL be captured into the data register and the FSM SHALL move to WRITE.
REQ-021 In WRITE: req_o=1, we_o=1, addr_o=current destination address, data_o=captured word; on ack_i=1 the remaining count SHALL decrement, both addresses SHALL increment by 4 (32-bit modulo wrap, 0xFFFFFFFC+4=0x00000000), and the FSM SHALL go to READ if the count is nonzero, else to DONE.
REQ-022 req_o, we_o, addr_o and data_o SHALL hold stable while ack_i=0.
REQ-023 In DONE: done_o=1 for exactly one cycle, req_o=0, busy_o=0; then IDLE.
REQ-024 busy_o SHALL be 1 exactly in READ and WRITE.
REQ-025 With ack_i held at 1 and start_i seen at cycle 0, word k reads at cycle 2k+1 and writes at cycle 2k+2, and done_o is high at cycle 2N+1; len_i=0 gives done_o at cycle 1 with no bus request.
REQ-026 In IDLE and DONE, req_o=0, we_o=0, and addr_o/data_o SHALL hold their last values.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force IDLE, busy_o=0, done_o=0, err_o=0, req_o=0, we_o=0, addr_o=0, data_o=0, and clear the count, address and data registers.
REQ-028 Reset mid-transfer SHALL abandon the copy; no done_o pulse follows.

Configuration
REQ-029 With RIB_DMA_TIMEOUT_EN defined, a wait counter SHALL count the consecutive cycles in READ/WRITE with ack_i=0. On reaching TIMEOUT_CYCLES it SHALL drop req_o, set err_o, and go to DONE, so done_o still pulses. The counter clears on each handshake.
REQ-030 Without RIB_DMA_TIMEOUT_EN, the block SHALL wait indefinitely for ack_i, and err_o SHALL be tied to 0.

Verification
REQ-031 Setup: src=0x0000_0000, dst=0x1000_0000, len=3, ack_i always 1, memory model returning 0xA0+n -> three write handshakes to 0x1000_0000/04/08 with data 0xA0/0xA1/0xA2, and done_o at cycle 7.
REQ-032 Setup: len=0 -> req_o stays 0, and done_o pulses at cycle 1.
REQ-033 Setup: len=2, ack_i delayed by a random 0-5 cycles per handshake -> addr_o/data_o stable while waiting, and correct data copied.
REQ-034 Setup: start_i pulsed again while busy_o=1 -> ignored, and the original copy completes unchanged.
REQ-035 Setup: rst asserted during the second WRITE of len=4 -> all outputs 0 asynchronously, no done_o, and a new start_i after release works.
REQ-036 Setup: TIMEOUT_EN built, TIMEOUT_CYCLES=8, ack_i held 0 -> req_o drops after 8 wait cycles, err_o=1, done_o pulses, and the next start_i clears err_o.

Source files
------------

// File: rtl/rib_dma.sv
// rtl/rib_dma.sv - RIB bus word-copy DMA engine; optional ack timeout via RIB_DMA_TIMEOUT_EN
module rib_dma #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [31:0] src_i,
   input  logic [31:0] dst_i,
   input  logic [15:0] len_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        req_o,
   output logic        we_o,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   input  logic [31:0] data_i,
   input  logic        ack_i
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

`ifdef RIB_DMA_TIMEOUT_EN
   localparam logic LP_TIMEOUT_EN = 1'b1;
`else
   localparam logic LP_TIMEOUT_EN = 1'b0;
`endif
   localparam logic [31:0] LP_WAIT_LAST = TIMEOUT_CYCLES - 32'd1;

   state_t      r_state, w_state_nx;
   logic [31:0] r_src, r_dst, r_addr, r_data;
   logic [15:0] r_cnt;
   logic        r_req, r_we, r_busy, r_done, r_err;

   logic [31:0] w_src_nx, w_dst_nx, w_addr_nx, w_data_nx;
   logic [15:0] w_cnt_nx;
   logic        w_req_nx, w_we_nx, w_busy_nx, w_done_nx, w_err_nx;

   logic [31:0] w_wait_cnt;
   logic        w_waiting;
   logic        w_timeout;

   assign w_waiting = ((r_state == S_READ) || (r_state == S_WRITE)) && !ack_i;
   assign w_timeout = LP_TIMEOUT_EN && w_waiting && (w_wait_cnt == LP_WAIT_LAST);

`ifdef RIB_DMA_TIMEOUT_EN
   logic [31:0] r_wait;

   // count consecutive unacknowledged bus cycles; a handshake or leaving the bus states clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait <= '0;
      end else if (w_waiting && !w_timeout) begin
         r_wait <= r_wait + 32'd1;
      end else begin
         r_wait <= '0;
      end
   end
   assign w_wait_cnt = r_wait;
`else
   assign w_wait_cnt = '0;
`endif

   // next state and next registered outputs; bus outputs are computed one cycle ahead
   always_comb begin
      w_state_nx = r_state;
      w_src_nx   = r_src;
      w_dst_nx   = r_dst;
      w_cnt_nx   = r_cnt;
      w_addr_nx  = r_addr;
      w_data_nx  = r_data;
      w_err_nx   = r_err;
      w_req_nx   = 1'b0;
      w_we_nx    = 1'b0;
      w_busy_nx  = 1'b0;
      w_done_nx  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_src_nx = src_i;
               w_dst_nx = dst_i;
               w_cnt_nx = len_i;
               w_err_nx = 1'b0;
               if (len_i == 16'd0) begin
                  w_state_nx = S_DONE;
                  w_done_nx  = 1'b1;
               end else begin
                  w_state_nx = S_READ;
                  w_req_nx   = 1'b1;
                  w_busy_nx  = 1'b1;
                  w_addr_nx  = src_i;
               end
            end
         end
         S_READ: begin
            if (w_timeout) begin
               w_state_nx = S_DONE;
               w_done_nx  = 1'b1;
               w_err_nx   = 1'b1;
            end else if (ack_i) begin
               w_state_nx = S_WRITE;
               w_data_nx  = data_i;
               w_addr_nx  = r_dst;
               w_req_nx   = 1'b1;
               w_we_nx    = 1'b1;
               w_busy_nx  = 1'b1;
            end else begin
               w_req_nx  = 1'b1;
               w_busy_nx = 1'b1;
            end
         end
         S_WRITE: begin
            if (w_timeout) begin
               w_state_nx = S_DONE;
               w_done_nx  = 1'b1;
               w_err_nx   = 1'b1;
            end else if (ack_i) begin
               w_cnt_nx = r_cnt - 16'd1;
               w_src_nx = r_src + 32'd4;
               w_dst_nx = r_dst + 32'd4;
               if (r_cnt == 16'd1) begin
                  w_state_nx = S_DONE;
                  w_done_nx  = 1'b1;
               end else begin
                  w_state_nx = S_READ;
                  w_addr_nx  = r_src + 32'd4;
                  w_req_nx   = 1'b1;
                  w_busy_nx  = 1'b1;
               end
            end else begin
               w_req_nx  = 1'b1;
               w_we_nx   = 1'b1;
               w_busy_nx = 1'b1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // state and output registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_src   <= w_src_nx;
         r_dst   <= w_dst_nx;
         r_cnt   <= w_cnt_nx;
         r_addr  <= w_addr_nx;
         r_data  <= w_data_nx;
         r_req   <= w_req_nx;
         r_we    <= w_we_nx;
         r_busy  <= w_busy_nx;
         r_done  <= w_done_nx;
         r_err   <= w_err_nx;
      end
   end

   assign busy_o = r_busy;
   assign done_o = r_done;
   assign err_o  = r_err;
   assign req_o  = r_req;
   assign we_o   = r_we;
   assign addr_o = r_addr;
   assign data_o = r_data;

endmodule
